// File: rtl/audio_timer_bank.sv
// audio_timer_bank: 1.79 MHz-derived audio channel timers; ports clk, reset_n, en179, wren/addr/D (AUDF write), stimer, sel15Khz, fastClk, link -> tick
module audio_timer_bank #(
  parameter int NUM_CH = 4,
  parameter int DIV64 = 28,
  parameter int DIV15 = 114
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      en179,
  input  logic                      wren,
  input  logic [$clog2(NUM_CH)-1:0] addr,
  input  logic [7:0]                D,
  input  logic                      stimer,
  input  logic                      sel15Khz,
  input  logic [NUM_CH/2-1:0]       fastClk,
  input  logic [NUM_CH/2-1:0]       link,
  output logic [NUM_CH-1:0]         tick
);
  localparam int W64 = $clog2(DIV64 + 1);
  localparam int W15 = $clog2(DIV15 + 1);
  logic [7:0] audf [NUM_CH];
  logic [W64-1:0] p64;
  logic [W15-1:0] p15;
  logic base;
  assign base = en179 && (sel15Khz ? p15 == W15'(DIV15 - 1) : p64 == W64'(DIV64 - 1));
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p64 <= '0;
      p15 <= '0;
      for (int i = 0; i < NUM_CH; i++) audf[i] <= '0;
    end else if (en179) begin
      p64 <= p64 == W64'(DIV64 - 1) ? '0 : p64 + W64'(1);
      p15 <= p15 == W15'(DIV15 - 1) ? '0 : p15 + W15'(1);
      if (wren) audf[addr] <= D;
    end
  end
  for (genvar g = 0; g < NUM_CH / 2; g++) begin : g_pair
    logic [8:0] lo, hi, lo_n, hi_n, lo_rl, lo_dec, hi_dec;
    logic [16:0] pair, pair_rl, pair_dec;
    logic tl, th, tl_n, th_n, en_lo;
    assign en_lo = fastClk[g] ? en179 : base;
    assign pair = {hi, lo[7:0]};
    assign lo_rl = {1'b0, audf[2*g]} + (fastClk[g] ? 9'd3 : 9'd0);
    assign pair_rl = {1'b0, audf[2*g+1], audf[2*g]} + (fastClk[g] ? 17'd6 : 17'd0);
    assign lo_dec = lo == '0 ? lo_rl : lo - 9'd1;
    assign hi_dec = hi == '0 ? {1'b0, audf[2*g+1]} : hi - 9'd1;
    assign pair_dec = pair == '0 ? pair_rl : pair - 17'd1;
    assign lo_n = stimer ? (link[g] ? {1'b0, pair_rl[7:0]} : lo_rl) :
                  !en_lo ? lo : link[g] ? {1'b0, pair_dec[7:0]} : lo_dec;
    assign hi_n = stimer ? (link[g] ? pair_rl[16:8] : {1'b0, audf[2*g+1]}) :
                  link[g] ? (en_lo ? pair_dec[16:8] : hi) : (base ? hi_dec : hi);
    assign tl_n = !stimer && !link[g] && en_lo && lo == '0;
    assign th_n = !stimer && (link[g] ? en_lo && pair == '0 : base && hi == '0);
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        lo <= '0;
        hi <= '0;
        tl <= 1'b0;
        th <= 1'b0;
      end else begin
        lo <= lo_n;
        hi <= hi_n;
        tl <= tl_n;
        th <= th_n;
      end
    end
    assign tick[2*g] = tl;
    assign tick[2*g+1] = th;
  end
endmodule

// File: doc/audio_timer_bank.md
AUDIO_TIMER_BANK -- requirements
Module: audio_timer_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, meaning number of audio channels; it SHALL be even and at least 2, and channels pair as (2p low, 2p+1 high).
REQ-002 SHALL have parameter DIV64, default 28, meaning the en179 pulses per 64 kHz base tick.
REQ-003 SHALL have parameter DIV15, default 114, meaning the en179 pulses per 15 kHz base tick.
REQ-004 clk  in  1  system clock; single clock domain.
REQ-005 reset_n  in  1  reset, asynchronous assert, active-low.
REQ-006 en179  in  1  one-clk-wide pulse per 1.79 MHz slow-clock edge.
REQ-007 wren  in  1  AUDF write request.
REQ-008 addr  in  clog2(NUM_CH)  AUDF channel select.
REQ-009 D  in  8  write data.
REQ-010 stimer  in  1  one-clk-wide pulse that restarts all channel counters.
REQ-011 sel15Khz  in  1  base clock select: 1 = 15 kHz, 0 = 64 kHz.
REQ-012 fastClk  in  NUM_CH/2  bit p clocks channel 2p from en179 directly.
REQ-013 link  in  NUM_CH/2  bit p joins pair p into one 16-bit counter.
REQ-014 tick  out  NUM_CH  registered one-clk underflow pulse per channel.

Function
REQ-015 SHALL write AUDF[addr] <= D on a clk edge where wren=1 and en179=1; wren without en179 SHALL be ignored.
REQ-016 SHALL run two free-running prescalers, mod DIV64 and mod DIV15, each advancing once per en179; the base tick SHALL assert on the en179 cycle where the selected prescaler equals its DIV-1.
REQ-017 A change of sel15Khz SHALL take effect at the next base tick of the newly selected prescaler; the prescalers SHALL never be reset by the selection change.
REQ-018 Channel clock enable: channel 2p SHALL use en179 if fastClk[p]=1, else the base tick; channel 2p+1 (unlinked) SHALL always use the base tick.
REQ-019 8-bit channel: on each clock enable, if cnt=0 the channel SHALL reload and pulse tick, else it SHALL decrement cnt by 1.
REQ-020 8-bit reload value SHALL be AUDF when base-clocked, giving a period of AUDF+1 base ticks.
REQ-021 8-bit reload value SHALL be AUDF+3 when fast-clocked, giving a period of AUDF+4 en179 pulses; 9-bit arithmetic SHALL be used, with no wrap.
REQ-022 Linked pair p: {cnt[2p+1],cnt[2p]} SHALL act as one 17-bit-safe counter clocked by channel 2p's enable.
REQ-023 Linked pair reload value SHALL be {AUDF[2p+1],AUDF[2p]}, plus 6 if fastClk[p]=1, giving periods of N+1 base ticks or N+7 en179 pulses.
REQ-024 Linked pair: tick[2p+1] SHALL pulse on 16-bit underflow and tick[2p] SHALL be held 0.
REQ-025 tick SHALL assert on the clk edge that processes the underflowing enable, giving 1-clk latency from that en179, and SHALL be exactly 1 clk wide.
REQ-026 stimer=1 SHALL load every counter with its current reload value and suppress all ticks that cycle; stimer SHALL win over a simultaneous underflow.
REQ-027 A write and a reload of the same channel in the same cycle SHALL reload with the old AUDF; the new value SHALL apply from the next reload.
REQ-028 AUDF writes SHALL never alter a running count.
REQ-029 A change of link or fastClk mid-count SHALL keep current cnt values and apply the new mode from the next enable.

Reset
REQ-030 reset_n=0 SHALL immediately clear all AUDF, cnt, prescalers and tick to 0.
REQ-031 Reset SHALL be released synchronously, so the first possible tick occurs at the first base tick after release.
REQ-032 Reset mid-count SHALL discard all state with no residual tick.

Verification
REQ-033 Bench SHALL cover: NUM_CH=4 defaults, AUDF0=9, 64 kHz, not fast -> tick[0] every 280 en179 pulses, each pulse 1 clk wide.
REQ-034 Bench SHALL cover: fastClk[0]=1, AUDF0=0 -> tick[0] every 4 en179 pulses; AUDF0=255 -> every 259.
REQ-035 Bench SHALL cover: link[0]=1, fastClk[0]=1, AUDF1=0x01, AUDF0=0x00 -> tick[1] every 263 en179 pulses, tick[0] stays 0.
REQ-036 Bench SHALL cover: sel15Khz=1, AUDF2=1 -> tick[2] every 228 en179 pulses; switching back to 64 kHz mid-run -> the next interval ends on a DIV64 boundary.
REQ-037 Bench SHALL cover: stimer pulse coincident with a channel-0 underflow -> no tick that cycle, and the next tick[0] arrives a full period later.
REQ-038 Bench SHALL cover: reset_n pulsed low mid-count -> tick=0 and all registers 0 during reset; after release, AUDF=0 gives tick[0] on the first 64 kHz base tick.
